// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised SPI master with per-transaction mode and bit order
module spi_master_param #(
    parameter int DATA_W   = 8,
    parameter int HALF_DIV = 50,
    parameter int N_SLAVES = 1,
    localparam int SEL_W   = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                start_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic [SEL_W-1:0]    cs_sel_i,
    input  logic                cpol_i,
    input  logic                cpha_i,
    input  logic                lsb_first_i,
    input  logic                miso_i,
    output logic                mosi_o,
    output logic                sclk_o,
    output logic [N_SLAVES-1:0] cs_n_o,
    output logic [DATA_W-1:0]   data_rx_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int CNT_W = $clog2(HALF_DIV);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(HALF_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PH_A,
        S_PH_B,
        S_HOLD,
        S_GAP
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [BIT_W-1:0]  bit_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic              cpol_q, cpha_q, lsb_q;
    logic              mosi_q, sclk_q, busy_q, done_q;
    logic [N_SLAVES-1:0] cs_n_q;
    logic [DATA_W-1:0] data_rx_q;

    logic tick, last_bit, sel_ok, accept;

    assign tick     = (cnt_q == '0);
    assign last_bit = (bit_q == LAST_BIT);
    assign sel_ok   = (32'(cs_sel_i) < N_SLAVES);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && sel_ok) begin
                    accept  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: if (tick) state_d = S_PH_A;
            S_PH_A:  if (tick) state_d = S_PH_B;
            S_PH_B:  if (tick) state_d = last_bit ? S_HOLD : S_PH_A;
            S_HOLD:  if (tick) state_d = S_GAP;
            S_GAP:   if (tick) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            mosi_q    <= 1'b0;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_n_q    <= '1;
            data_rx_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;

            if (accept) begin
                cnt_q <= RELOAD;
            end else if (state_q != S_IDLE) begin
                cnt_q <= tick ? RELOAD : cnt_q - CNT_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        tx_q   <= data_i;
                        cpol_q <= cpol_i;
                        cpha_q <= cpha_i;
                        lsb_q  <= lsb_first_i;
                        bit_q  <= '0;
                        busy_q <= 1'b1;
                        cs_n_q <= ~(N_SLAVES'(1) << cs_sel_i);
                        sclk_q <= cpol_i;
                        mosi_q <= lsb_first_i ? data_i[0] : data_i[DATA_W-1];
                    end
                end
                S_SETUP: begin
                    if (tick) sclk_q <= cpol_q ^ cpha_q;
                end
                S_PH_A: begin
                    if (tick) begin
                        sclk_q <= cpol_q ^ ~cpha_q;
                        rx_q   <= lsb_q ? {miso_i, rx_q[DATA_W-1:1]}
                                        : {rx_q[DATA_W-2:0], miso_i};
                    end
                end
                S_PH_B: begin
                    if (tick) begin
                        if (last_bit) begin
                            sclk_q <= cpol_q;
                        end else begin
                            sclk_q <= cpol_q ^ cpha_q;
                            mosi_q <= lsb_q ? tx_q[1] : tx_q[DATA_W-2];
                            tx_q   <= lsb_q ? (tx_q >> 1) : (tx_q << 1);
                            bit_q  <= bit_q + BIT_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        cs_n_q    <= '1;
                        data_rx_q <= rx_q;
                        done_q    <= 1'b1;
                        mosi_q    <= 1'b0;
                    end
                end
                S_GAP: begin
                    // busy stays high through GAP so a held start cannot shorten CS-high time
                    if (tick) busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mosi_o    = mosi_q;
    assign sclk_o    = sclk_q;
    assign cs_n_o    = cs_n_q;
    assign data_rx_o = data_rx_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule
